// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: reset defaults and the IF/ID slot layout used by decode.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEF   = 32'd1;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    function automatic if_id_t make_slot(input logic [31:0] pc, input logic [31:0] instr);
        if_id_t s;
        s.valid = 1'b1;
        s.pc    = pc;
        s.instr = instr;
        return s;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: word-addressed PC, 1-cycle synchronous imem, registered IF/ID slot
// with a one-entry skid buffer for decode stalls and squash on branch redirect.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] PC_STEP   = PC_STEP_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] next,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush
);

    logic        issue;
    logic [31:0] pc;
    logic        req_vld;
    logic [31:0] req_pc;
    if_id_t      if_id, if_id_d;
    if_id_t      skid,  skid_d;

    // No new fetch while decode is stalled or the path is being redirected.
    assign issue     = ~rst & ~stall & ~jump;
    assign imem_en   = issue;
    assign imem_addr = pc;
    assign flush     = jump;

    assign if_valid  = if_id.valid;
    assign if_pc     = if_id.pc;
    assign if_instr  = if_id.instr;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (jump) begin
            pc <= next;
        end else if (issue) begin
            pc <= pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_vld <= 1'b0;
            req_pc  <= '0;
        end else begin
            req_vld <= issue;
            req_pc  <= pc;
        end
    end

    // NOTE: every combinational output is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        if_id_d = if_id;
        skid_d  = skid;
        if (jump) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
            skid_d.valid  = 1'b0;
        end else if (stall) begin
            if (req_vld) begin
                skid_d = make_slot(req_pc, imem_rdata);
            end
        end else if (skid.valid) begin
            if_id_d      = skid;
            skid_d.valid = 1'b0;
        end else if (req_vld) begin
            if_id_d = make_slot(req_pc, imem_rdata);
        end else begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id.valid <= 1'b0;
            if_id.pc    <= '0;
            if_id.instr <= NOP_INSTR;
            skid        <= '0;
        end else begin
            if_id <= if_id_d;
            skid  <= skid_d;
        end
    end

    // Skid drains before any new fetch returns, so one entry is always enough.
    assert property (@(posedge clk) disable iff (rst) !(skid.valid && req_vld && !stall));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboard of accepted IF/ID entries plus point checks.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, jump;
    logic [31:0] next;
    logic        imem_en;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc, if_instr;
    logic        flush;

    logic        stall2, jump2;
    logic [31:0] next2;
    logic        imem_en2;
    logic [31:0] imem_addr2, imem_rdata2;
    logic        if_valid2;
    logic [31:0] if_pc2, if_instr2;
    logic        flush2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .jump(jump), .next(next),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .flush(flush)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFF)) dut2 (
        .clk(clk), .rst(rst), .stall(stall2), .jump(jump2), .next(next2),
        .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .if_valid(if_valid2), .if_pc(if_pc2), .if_instr(if_instr2), .flush(flush2)
    );

    // Instruction memory contents: word at address a holds 0x100 + a.
    always @(posedge clk) begin
        if (imem_en)  imem_rdata  <= 32'h100 + imem_addr;
        if (imem_en2) imem_rdata2 <= 32'h100 + imem_addr2;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = 32'h100 + pc;
        sb.push_back(e);
    endtask

    task automatic step(input logic s, input logic j, input logic [31:0] n);
        @(posedge clk);
        #1;
        stall = s;
        jump  = j;
        next  = n;
        @(negedge clk);
    endtask

    // Decode accepts the IF/ID entry when it is valid, not stalled and not flushed.
    always @(negedge clk) begin
        if (!rst && if_valid && !stall && !jump) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got pc %h want none", if_pc);
            end else begin
                mon_e = sb.pop_front();
                check("sb_pc", if_pc, mon_e.pc);
                check("sb_instr", if_instr, mon_e.instr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; jump = 1'b0; next = '0;
        stall2 = 1'b0; jump2 = 1'b0; next2 = '0;
        @(negedge clk);
        check("rst_if_valid", if_valid, 0);
        check("rst_if_pc", if_pc, 0);
        check("rst_if_instr", if_instr, 32'h13);
        check("rst_imem_en", imem_en, 0);
        check("rst_imem_addr", imem_addr, 0);

        // Test 1 and 2: stream from reset, then a 3-cycle stall.
        for (int i = 0; i < 8; i++) expect_fetch(i);
        @(posedge clk); #1; rst = 1'b0; @(negedge clk);             // cycle 0
        check("c0_imem_en", imem_en, 1);
        check("c0_imem_addr", imem_addr, 0);
        check("c0_if_valid", if_valid, 0);
        check("w0_imem_addr", imem_addr2, 32'hFFFF_FFFF);
        check("w0_imem_en", imem_en2, 1);
        step(0, 0, 0);                                               // cycle 1
        check("c1_imem_addr", imem_addr, 1);
        check("c1_if_valid", if_valid, 0);
        check("w1_imem_addr", imem_addr2, 0);
        step(0, 0, 0);                                               // cycle 2
        check("c2_if_valid", if_valid, 1);
        check("c2_if_pc", if_pc, 0);
        check("c2_if_instr", if_instr, 32'h100);
        check("w2_if_valid", if_valid2, 1);
        check("w2_if_pc", if_pc2, 32'hFFFF_FFFF);
        check("w2_if_instr", if_instr2, 32'h0000_00FF);
        step(0, 0, 0);                                               // cycle 3
        check("w3_if_pc", if_pc2, 0);
        check("w3_if_instr", if_instr2, 32'h100);
        check("w3_flush", flush2, 0);
        step(0, 0, 0);                                               // cycle 4
        step(0, 0, 0);                                               // cycle 5
        step(1, 0, 0);                                               // cycle 6
        check("st6_imem_addr", imem_addr, 6);
        check("st6_imem_en", imem_en, 0);
        step(1, 0, 0);                                               // cycle 7
        check("st7_skid_valid", dut.skid.valid, 1);
        step(1, 0, 0);                                               // cycle 8
        check("st8_imem_addr", imem_addr, 6);
        check("st8_if_pc", if_pc, 4);
        check("st8_if_valid", if_valid, 1);
        for (int c = 9; c <= 12; c++) step(0, 0, 0);

        // Test 3: redirect to 0x40 mid-stream.
        for (int i = 0; i < 3; i++) expect_fetch(32'h40 + i);
        step(0, 1, 32'h40);                                          // cycle 13
        check("j13_flush", flush, 1);
        check("j13_imem_en", imem_en, 0);
        step(0, 0, 0);                                               // cycle 14
        check("j14_if_valid", if_valid, 0);
        check("j14_if_instr", if_instr, 32'h13);
        check("j14_imem_addr", imem_addr, 32'h40);
        check("j14_flush", flush, 0);
        step(0, 0, 0);                                               // cycle 15
        check("j15_if_valid", if_valid, 0);
        step(0, 0, 0);                                               // cycle 16
        check("j16_if_pc", if_pc, 32'h40);
        step(0, 0, 0);                                               // cycle 17
        step(0, 0, 0);                                               // cycle 18

        // Test 4: jump together with stall while the skid is full.
        expect_fetch(32'h80);
        expect_fetch(32'h81);
        step(1, 0, 0);                                               // cycle 19
        step(1, 1, 32'h80);                                          // cycle 20
        check("js20_skid_valid", dut.skid.valid, 1);
        check("js20_flush", flush, 1);
        step(0, 0, 0);                                               // cycle 21
        check("js21_if_valid", if_valid, 0);
        check("js21_skid_valid", dut.skid.valid, 0);
        check("js21_imem_addr", imem_addr, 32'h80);
        step(0, 0, 0);                                               // cycle 22
        check("js22_if_valid", if_valid, 0);
        step(0, 0, 0);                                               // cycle 23
        step(0, 0, 0);                                               // cycle 24

        // Test 6: reset pulsed mid-stall with the skid full.
        step(1, 0, 0);                                               // cycle 25
        step(1, 0, 0);                                               // cycle 26
        check("r26_skid_valid", dut.skid.valid, 1);
        check("r26_if_pc", if_pc, 32'h82);
        #1; rst = 1'b1;
        #1;
        check("r_if_valid", if_valid, 0);
        check("r_if_pc", if_pc, 0);
        check("r_if_instr", if_instr, 32'h13);
        check("r_imem_en", imem_en, 0);
        check("r_imem_addr", imem_addr, 0);
        check("r_skid_valid", dut.skid.valid, 0);
        expect_fetch(0);
        expect_fetch(1);
        @(posedge clk); #1; rst = 1'b0; stall = 1'b0; @(negedge clk); // cycle 27
        check("r27_imem_addr", imem_addr, 0);
        check("r27_if_valid", if_valid, 0);
        step(0, 0, 0);                                               // cycle 28
        step(0, 0, 0);                                               // cycle 29
        check("r29_if_pc", if_pc, 0);
        step(0, 0, 0);                                               // cycle 30
        step(1, 0, 0);                                               // cycle 31
        step(1, 0, 0);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
